instr_fetch_unit: RTL and testbench

- Holds the program counter and fetches 32-bit LEGv8 instructions from instruction memory over a req/ack handshake.
- Presents each instruction to decode, and so to the sign extender (Instruction[25:0]), with a valid/ready handshake.
- Computes the next PC as sequential (+4) or as a redirect using the sign-extended, pre-shifted branch offset returned by the sign extender.
- Sits directly upstream of the sign extender and consumes its output for branch targets.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instr_fetch_unit_next_pc_calc.sv | 20 ++
 rtl/instr_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro used by the fetch unit: FETCH_TIMEOUT_EN.
package fetch_pkg;

   localparam int ADDR_W      = 64;
   localparam int INSTR_W     = 32;
   localparam int INSTR_BYTES = 4;

   // Fetch sequencer states; FAULT is only reachable with the timeout enabled.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC: sequential (+4) or redirect by the pre-shifted,
// sign-extended offset from the sign extender. Wraps modulo 2^64.
module next_pc_calc
   import fetch_pkg::*;
(
   input  logic [ADDR_W-1:0] FetchPC,
   input  logic [ADDR_W-1:0] ExtImm,
   input  logic              Redirect,
   output logic [ADDR_W-1:0] NextPC
);

   logic [ADDR_W-1:0] w_offset;

   // Pick the branch offset or the instruction size, then add.
   always_comb begin
      w_offset = Redirect ? ExtImm : ADDR_W'(INSTR_BYTES);
      NextPC   = FetchPC + w_offset;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 instruction fetch unit: holds the PC, fetches over ImemReq/ImemAck,
// presents instructions to decode and computes the next PC.
// Optional macro FETCH_TIMEOUT_EN adds a REQ timeout with a sticky Fault.
//
// Handshakes: ImemReq stays high with a stable ImemAddr until ImemAck is
// sampled high on a rising edge; InstValid stays high with Instruction and
// FetchPC stable until InstReady is sampled high on a rising edge. Redirect
// and ExtImm only matter on that accepting edge.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC       = 64'h0,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic                CLK,
   input  logic                Reset,
   output logic [ADDR_W-1:0]   ImemAddr,
   output logic                ImemReq,
   input  logic                ImemAck,
   input  logic [INSTR_W-1:0]  ImemData,
   output logic [INSTR_W-1:0]  Instruction,
   output logic [ADDR_W-1:0]   FetchPC,
   output logic                InstValid,
   input  logic                InstReady,
   input  logic                Redirect,
   input  logic [ADDR_W-1:0]   ExtImm,
   output logic                Fault,
   output fetch_state_t        DbgState
);

   fetch_state_t       r_state;
   fetch_state_t       w_next_state;
   logic               r_started;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;
   logic               w_load;
   logic               w_advance;
   logic               w_timeout;
   logic [ADDR_W-1:0]  w_next_pc;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_fault;
`endif

   next_pc_calc u_next_pc (
      .FetchPC  (r_fetch_pc),
      .ExtImm   (ExtImm),
      .Redirect (Redirect),
      .NextPC   (w_next_pc)
   );

   // Next-state and transfer strobes; the first edge after reset release
   // is spent in IDLE so the request starts one cycle later.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_advance    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_started) w_next_state = REQ;
         end
         REQ: begin
            if (ImemAck) begin
               w_next_state = HOLD;
               w_load       = 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_next_state = FAULT;
               w_timeout    = 1'b1;
            end
`endif
         end
         HOLD: begin
            if (InstReady) begin
               w_next_state = REQ;
               w_advance    = 1'b1;
            end
         end
         FAULT: begin
`ifdef FETCH_TIMEOUT_EN
            w_next_state = FAULT;
`else
            w_next_state = IDLE;
`endif
         end
         default: w_next_state = IDLE;
      endcase
   end

   // State register plus the post-reset start flag.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_started <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_started <= 1'b1;
      end
   end

   // PC, instruction register and valid flag.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_pc       <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_instr    <= '0;
         r_valid    <= 1'b0;
      end else begin
         if (w_load) begin
            r_instr    <= ImemData;
            r_fetch_pc <= r_pc;
            r_valid    <= 1'b1;
         end
         if (w_advance) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // Count REQ cycles without ack; latch Fault when the budget runs out.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_cnt   <= '0;
         r_fault <= 1'b0;
      end else begin
         if (r_state == REQ && !ImemAck && !w_timeout) r_cnt <= r_cnt + 1'b1;
         else                                          r_cnt <= '0;
         if (w_timeout) r_fault <= 1'b1;
      end
   end
   assign Fault = r_fault;
`else
   assign Fault = 1'b0;
`endif

   assign ImemAddr    = r_pc;
   assign ImemReq     = (r_state == REQ);
   assign Instruction = r_instr;
   assign FetchPC     = r_fetch_pc;
   assign InstValid   = r_valid;
   assign DbgState    = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table,
// randomized transactions against a PC/instruction model, reset and
// (with FETCH_TIMEOUT_EN) timeout sequences.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam logic [63:0] RST_PC = 64'h0;

   logic         CLK = 1'b0;
   logic         Reset;
   logic [63:0]  ImemAddr;
   logic         ImemReq;
   logic         ImemAck;
   logic [31:0]  ImemData;
   logic [31:0]  Instruction;
   logic [63:0]  FetchPC;
   logic         InstValid;
   logic         InstReady;
   logic         Redirect;
   logic [63:0]  ExtImm;
   logic         Fault;
   fetch_state_t DbgState;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] m_pc;
   logic [31:0] exp_q[$];

   // clock / reset block
   always #5 CLK = ~CLK;

   instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .Reset(Reset), .ImemAddr(ImemAddr), .ImemReq(ImemReq),
      .ImemAck(ImemAck), .ImemData(ImemData), .Instruction(Instruction),
      .FetchPC(FetchPC), .InstValid(InstValid), .InstReady(InstReady),
      .Redirect(Redirect), .ExtImm(ExtImm), .Fault(Fault), .DbgState(DbgState)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive the inputs to idle values.
   task automatic drive_idle();
      ImemAck   = 1'b0;
      ImemData  = 32'h0;
      InstReady = 1'b0;
      Redirect  = 1'b0;
      ExtImm    = 64'h0;
   endtask

   // Reset, release, and walk through the IDLE cycle into REQ.
   task automatic do_reset_release();
      Reset = 1'b1;
      drive_idle();
      repeat (3) tick();
      chk("rst_req", 64'(ImemReq), 64'h0);
      chk("rst_valid", 64'(InstValid), 64'h0);
      chk("rst_instr", 64'(Instruction), 64'h0);
      chk("rst_fetchpc", FetchPC, RST_PC);
      chk("rst_addr", ImemAddr, RST_PC);
      chk("rst_fault", 64'(Fault), 64'h0);
      Reset = 1'b0;
      tick();
      chk("edge0_state", 64'(DbgState), 64'(IDLE));
      chk("edge0_req", 64'(ImemReq), 64'h0);
      tick();
      chk("edge1_req", 64'(ImemReq), 64'h1);
      chk("edge1_addr", ImemAddr, RST_PC);
      m_pc = RST_PC;
      exp_q.delete();
   endtask

   // One fetch: starts and ends #1 after an edge with the DUT requesting.
   task automatic run_txn(input logic [31:0] data, input int ack_dly, input int rdy_dly,
                          input logic redir, input logic [63:0] imm);
      logic [31:0] e;
      chk("txn_req", 64'(ImemReq), 64'h1);
      chk("txn_addr", ImemAddr, m_pc);
      for (int i = 0; i < ack_dly; i++) begin
         ImemAck  = 1'b0;
         ImemData = $urandom;
         tick();
         chk("wait_req", 64'(ImemReq), 64'h1);
         chk("wait_valid", 64'(InstValid), 64'h0);
         chk("wait_addr", ImemAddr, m_pc);
      end
      ImemAck  = 1'b1;
      ImemData = data;
      exp_q.push_back(data);
      tick();
      ImemAck = 1'b0;
      e = exp_q.pop_front();
      chk("ack_valid", 64'(InstValid), 64'h1);
      chk("ack_instr", 64'(Instruction), 64'(e));
      chk("ack_fetchpc", FetchPC, m_pc);
      chk("ack_req", 64'(ImemReq), 64'h0);
      for (int i = 0; i < rdy_dly; i++) begin
         InstReady = 1'b0;
         Redirect  = 1'($urandom_range(0, 1));
         ExtImm    = {$urandom, $urandom};
         ImemAck   = 1'($urandom_range(0, 1));
         ImemData  = $urandom;
         tick();
         chk("hold_instr", 64'(Instruction), 64'(e));
         chk("hold_fetchpc", FetchPC, m_pc);
         chk("hold_valid", 64'(InstValid), 64'h1);
         chk("hold_req", 64'(ImemReq), 64'h0);
      end
      ImemAck   = 1'b0;
      InstReady = 1'b1;
      Redirect  = redir;
      ExtImm    = imm;
      tick();
      drive_idle();
      m_pc = redir ? m_pc + imm : m_pc + 64'd4;
      chk("next_req", 64'(ImemReq), 64'h1);
      chk("next_valid", 64'(InstValid), 64'h0);
      chk("next_addr", ImemAddr, m_pc);
   endtask

   typedef struct {
      logic [31:0] data;
      int          ack_dly;
      int          rdy_dly;
      logic        redir;
      logic [63:0] imm;
      logic [63:0] exp_next;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{32'h8B020020, 0, 0, 1'b0, 64'h0, 64'h4};
      vt[1] = '{32'hB4000040, 1, 2, 1'b1, 64'hC, 64'h10};
      vt[2] = '{32'h17FFFFFE, 0, 5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8};
      vt[3] = '{32'h14000003, 0, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFFC};
      vt[4] = '{32'hD503201F, 0, 0, 1'b0, 64'h0, 64'h0};
      vt[5] = '{32'hF84003E1, 2, 3, 1'b0, 64'h0, 64'h4};

      do_reset_release();

      // directed table
      for (int i = 0; i < 6; i++) begin
         run_txn(vt[i].data, vt[i].ack_dly, vt[i].rdy_dly, vt[i].redir, vt[i].imm);
         chk($sformatf("vec%0d_next", i), ImemAddr, vt[i].exp_next);
      end

      // randomized transactions against the model
      for (int i = 0; i < 40; i++) begin
         logic [63:0] imm;
         imm = 64'(signed'($urandom_range(0, 4095)) - 2048) << 2;
         run_txn($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), imm);
      end

      // reset mid-REQ with no ack: outputs return asynchronously
      tick();
      tick();
      Reset = 1'b1;
      #1;
      chk("midrst_req", 64'(ImemReq), 64'h0);
      chk("midrst_valid", 64'(InstValid), 64'h0);
      chk("midrst_addr", ImemAddr, RST_PC);
      do_reset_release();
      run_txn(32'h91000421, 0, 0, 1'b0, 64'h0);
      chk("restart_next", ImemAddr, RST_PC + 64'h4);

`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("to_nofault", 64'(Fault), 64'h0);
         chk("to_req", 64'(ImemReq), 64'h1);
      end
      tick();
      chk("to_fault", 64'(Fault), 64'h1);
      chk("to_req_off", 64'(ImemReq), 64'h0);
      ImemAck = 1'b1;
      repeat (3) tick();
      ImemAck = 1'b0;
      chk("to_sticky", 64'(Fault), 64'h1);
      chk("to_sticky_valid", 64'(InstValid), 64'h0);
      do_reset_release();
      chk("to_cleared", 64'(Fault), 64'h0);
`else
      chk("fault_tied", 64'(Fault), 64'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
